// File: rtl/axi_sram_responder_if.sv
// AXI4 bus bundle (AW, W, B, AR, R) shared by masters and the SRAM responder.
// Latency: none, wires only.
// Backpressure: plain valid/ready on every channel.
interface AXI_BUS #(
    parameter int unsigned AXI_ADDR_WIDTH = 64,
    parameter int unsigned AXI_DATA_WIDTH = 128,
    parameter int unsigned AXI_ID_WIDTH   = 4,
    parameter int unsigned AXI_USER_WIDTH = 1
);
    localparam int unsigned AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8;

    logic [AXI_ID_WIDTH-1:0]   aw_id;
    logic [AXI_ADDR_WIDTH-1:0] aw_addr;
    logic [7:0]                aw_len;
    logic [2:0]                aw_size;
    logic [1:0]                aw_burst;
    logic                      aw_valid;
    logic                      aw_ready;

    logic [AXI_DATA_WIDTH-1:0] w_data;
    logic [AXI_STRB_WIDTH-1:0] w_strb;
    logic                      w_last;
    logic                      w_valid;
    logic                      w_ready;

    logic [AXI_ID_WIDTH-1:0]   b_id;
    logic [1:0]                b_resp;
    logic [AXI_USER_WIDTH-1:0] b_user;
    logic                      b_valid;
    logic                      b_ready;

    logic [AXI_ID_WIDTH-1:0]   ar_id;
    logic [AXI_ADDR_WIDTH-1:0] ar_addr;
    logic [7:0]                ar_len;
    logic [2:0]                ar_size;
    logic [1:0]                ar_burst;
    logic                      ar_valid;
    logic                      ar_ready;

    logic [AXI_ID_WIDTH-1:0]   r_id;
    logic [AXI_DATA_WIDTH-1:0] r_data;
    logic [1:0]                r_resp;
    logic                      r_last;
    logic [AXI_USER_WIDTH-1:0] r_user;
    logic                      r_valid;
    logic                      r_ready;

    modport Master (
        output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_valid, input aw_ready,
        output w_data, w_strb, w_last, w_valid, input w_ready,
        input b_id, b_resp, b_user, b_valid, output b_ready,
        output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_valid, input ar_ready,
        input r_id, r_data, r_resp, r_last, r_user, r_valid, output r_ready
    );

    modport Slave (
        input aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_valid, output aw_ready,
        input w_data, w_strb, w_last, w_valid, output w_ready,
        output b_id, b_resp, b_user, b_valid, input b_ready,
        input ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_valid, output ar_ready,
        output r_id, r_data, r_resp, r_last, r_user, r_valid, input r_ready
    );
endinterface

// File: rtl/axi_sram_responder.sv
// AXI4 responder backed by a 1R1W word array; FIXED/INCR bursts, OKAY/SLVERR/DECERR.
// Latency: W beat written on its handshake edge; AR to first rvalid 2 cycles, 1 beat per 2 cycles.
// Backpressure: B and R outputs are registered and held until bready/rready.
module axi_sram_responder #(
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned DATA_WIDTH = 128,
    parameter int unsigned ID_WIDTH   = 4,
    parameter int unsigned USER_WIDTH = 1,
    parameter int unsigned MEM_WORDS  = 4096,
    parameter logic [63:0] BASE_ADDR  = 64'h8000_0000
) (
    input logic   clk,
    input logic   rst,
    AXI_BUS.Slave axi
);
    localparam int unsigned BPW   = DATA_WIDTH / 8;
    localparam int unsigned OFF_W = $clog2(BPW);
    localparam int unsigned IDX_W = $clog2(MEM_WORDS);
    localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] SPAN = ADDR_WIDTH'(MEM_WORDS * BPW);

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Subtract first so the upper bound cannot overflow at the top of the address map.
    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return (a >= BASE) && ((a - BASE) < SPAN);
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
        return IDX_W'((a - BASE) >> OFF_W);
    endfunction

    // Wider-than-bus beats and WRAP/reserved bursts run their beat count but never touch the array.
    function automatic logic burst_ok(input logic [2:0] size, input logic [1:0] burst);
        return (32'(size) <= OFF_W) && ((burst == BURST_FIXED) || (burst == BURST_INCR));
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a,
                                                        input logic [2:0] size,
                                                        input logic [1:0] burst);
        return (burst == BURST_INCR) ? a + (ADDR_WIDTH'(1) << size) : a;
    endfunction

    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

    // ---------------- write side ----------------
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    w_state_t              w_state;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [7:0]            w_len, w_cnt;
    logic [2:0]            w_size;
    logic [1:0]            w_burst;
    logic                  w_dec, w_slv;
    logic                  aw_rdy, w_rdy, b_vld;
    logic [1:0]            b_rsp;
    logic [ID_WIDTH-1:0]   b_id;

    logic w_fire, w_last_beat, w_ok, w_hit, w_dec_n, w_slv_n;
    assign w_fire      = w_rdy && axi.w_valid;
    assign w_last_beat = (w_cnt == w_len);
    assign w_ok        = burst_ok(w_size, w_burst);
    assign w_hit       = in_range(w_addr);
    assign w_dec_n     = w_dec || (w_ok && !w_hit);
    assign w_slv_n     = w_slv || !w_ok || (axi.w_last != w_last_beat);

    // Write FSM: latch AW, count W beats, collect error flags, then hold B until bready.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_state <= W_IDLE;
            aw_rdy  <= 1'b1;
            w_rdy   <= 1'b0;
            b_vld   <= 1'b0;
            b_rsp   <= RESP_OKAY;
            b_id    <= '0;
        end else begin
            unique case (w_state)
                W_IDLE: if (axi.aw_valid) begin
                    b_id    <= axi.aw_id;
                    w_addr  <= axi.aw_addr;
                    w_len   <= axi.aw_len;
                    w_size  <= axi.aw_size;
                    w_burst <= axi.aw_burst;
                    w_cnt   <= 8'd0;
                    w_dec   <= 1'b0;
                    w_slv   <= 1'b0;
                    aw_rdy  <= 1'b0;
                    w_rdy   <= 1'b1;
                    w_state <= W_DATA;
                end
                W_DATA: if (w_fire) begin
                    w_dec <= w_dec_n;
                    w_slv <= w_slv_n;
                    if (w_last_beat) begin
                        w_rdy   <= 1'b0;
                        b_vld   <= 1'b1;
                        b_rsp   <= w_dec_n ? RESP_DECERR : (w_slv_n ? RESP_SLVERR : RESP_OKAY);
                        w_state <= W_RESP;
                    end else begin
                        w_cnt  <= w_cnt + 8'd1;
                        w_addr <= next_addr(w_addr, w_size, w_burst);
                    end
                end
                W_RESP: if (axi.b_ready) begin
                    b_vld   <= 1'b0;
                    aw_rdy  <= 1'b1;
                    w_state <= W_IDLE;
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // Byte-masked array write on the W handshake edge; a reset on that edge wins and drops the beat.
    always_ff @(posedge clk) begin
        if (!rst && w_fire && w_ok && w_hit) begin
            for (int unsigned b = 0; b < BPW; b++) begin
                if (axi.w_strb[b]) mem[word_idx(w_addr)][b*8 +: 8] <= axi.w_data[b*8 +: 8];
            end
        end
    end

    // ---------------- read side ----------------
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_VALID} r_state_t;
    r_state_t              r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [7:0]            r_len, r_cnt;
    logic [2:0]            r_size;
    logic [1:0]            r_burst;
    logic                  ar_rdy, r_vld, r_lst;
    logic [DATA_WIDTH-1:0] r_dat;
    logic [1:0]            r_rsp;
    logic [ID_WIDTH-1:0]   r_id;

    // Read FSM: one fetch cycle per beat, then hold the registered beat until rready.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= R_IDLE;
            ar_rdy  <= 1'b1;
            r_vld   <= 1'b0;
            r_dat   <= '0;
            r_rsp   <= RESP_OKAY;
            r_lst   <= 1'b0;
            r_id    <= '0;
        end else begin
            unique case (r_state)
                R_IDLE: if (axi.ar_valid) begin
                    r_id    <= axi.ar_id;
                    r_addr  <= axi.ar_addr;
                    r_len   <= axi.ar_len;
                    r_size  <= axi.ar_size;
                    r_burst <= axi.ar_burst;
                    r_cnt   <= 8'd0;
                    ar_rdy  <= 1'b0;
                    r_state <= R_FETCH;
                end
                R_FETCH: begin
                    r_vld   <= 1'b1;
                    r_lst   <= (r_cnt == r_len);
                    r_state <= R_VALID;
                    if (!burst_ok(r_size, r_burst)) begin
                        r_dat <= '0;
                        r_rsp <= RESP_SLVERR;
                    end else if (!in_range(r_addr)) begin
                        r_dat <= '0;
                        r_rsp <= RESP_DECERR;
                    end else begin
                        r_dat <= mem[word_idx(r_addr)];
                        r_rsp <= RESP_OKAY;
                    end
                end
                R_VALID: if (axi.r_ready) begin
                    r_vld <= 1'b0;
                    if (r_lst) begin
                        ar_rdy  <= 1'b1;
                        r_state <= R_IDLE;
                    end else begin
                        r_cnt   <= r_cnt + 8'd1;
                        r_addr  <= next_addr(r_addr, r_size, r_burst);
                        r_state <= R_FETCH;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    assign axi.aw_ready = aw_rdy;
    assign axi.w_ready  = w_rdy;
    assign axi.b_valid  = b_vld;
    assign axi.b_resp   = b_rsp;
    assign axi.b_id     = b_id;
    assign axi.b_user   = {USER_WIDTH{1'b0}};
    assign axi.ar_ready = ar_rdy;
    assign axi.r_valid  = r_vld;
    assign axi.r_data   = r_dat;
    assign axi.r_resp   = r_rsp;
    assign axi.r_last   = r_lst;
    assign axi.r_id     = r_id;
    assign axi.r_user   = {USER_WIDTH{1'b0}};
endmodule

// File: tb/tb_axi_sram_responder.sv
// Directed bench for axi_sram_responder: writes, reads, strobes, errors, backpressure, reset.
// Latency: expects rvalid two cycles after the AR handshake.
// Backpressure: holds rready/bready low to check that outputs stay put.
module tb_axi_sram_responder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    AXI_BUS #(.AXI_ADDR_WIDTH(64), .AXI_DATA_WIDTH(128), .AXI_ID_WIDTH(4), .AXI_USER_WIDTH(1)) axi_bus ();

    axi_sram_responder dut (.clk(clk), .rst(rst), .axi(axi_bus));

    int checks = 0;
    int failures = 0;

    logic [127:0] wd [8];
    logic [15:0]  ws [8];
    logic         wl [8];
    logic [127:0] rd [8];
    logic [1:0]   rr [8];
    logic         rl [8];
    logic [3:0]   ri [8];

    task automatic send_aw(input logic [63:0] a, input logic [7:0] len, input logic [2:0] sz,
                           input logic [1:0] bt, input logic [3:0] id, output bit ok);
        ok = 0;
        axi_bus.aw_addr = a; axi_bus.aw_len = len; axi_bus.aw_size = sz;
        axi_bus.aw_burst = bt; axi_bus.aw_id = id; axi_bus.aw_valid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            if (axi_bus.aw_ready) ok = 1;
            @(posedge clk); #1;
        end
        axi_bus.aw_valid = 1'b0;
    endtask

    task automatic send_ar(input logic [63:0] a, input logic [7:0] len, input logic [2:0] sz,
                           input logic [1:0] bt, input logic [3:0] id, output bit ok);
        ok = 0;
        axi_bus.ar_addr = a; axi_bus.ar_len = len; axi_bus.ar_size = sz;
        axi_bus.ar_burst = bt; axi_bus.ar_id = id; axi_bus.ar_valid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            if (axi_bus.ar_ready) ok = 1;
            @(posedge clk); #1;
        end
        axi_bus.ar_valid = 1'b0;
    endtask

    task automatic send_w(input logic [127:0] d, input logic [15:0] s, input logic l, output bit ok);
        ok = 0;
        axi_bus.w_data = d; axi_bus.w_strb = s; axi_bus.w_last = l; axi_bus.w_valid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            if (axi_bus.w_ready) ok = 1;
            @(posedge clk); #1;
        end
        axi_bus.w_valid = 1'b0;
    endtask

    task automatic wait_b(output bit ok);
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            if (axi_bus.b_valid) begin ok = 1; break; end
            @(posedge clk); #1;
        end
    endtask

    task automatic recv_r(output logic [127:0] d, output logic [1:0] rsp, output logic l,
                          output logic [3:0] id, output bit ok);
        ok = 0; d = 'x; rsp = 'x; l = 1'bx; id = 'x;
        for (int i = 0; i < 50; i++) begin
            if (axi_bus.r_valid) begin ok = 1; break; end
            @(posedge clk); #1;
        end
        if (ok) begin
            d = axi_bus.r_data; rsp = axi_bus.r_resp; l = axi_bus.r_last; id = axi_bus.r_id;
            axi_bus.r_ready = 1'b1; @(posedge clk); #1; axi_bus.r_ready = 1'b0;
        end
    endtask

    // Full write burst from wd/ws/wl, B accepted as soon as it shows up.
    task automatic do_write(input logic [63:0] a, input logic [7:0] len, input logic [2:0] sz,
                            input logic [1:0] bt, input logic [3:0] id,
                            output bit ok, output logic [1:0] resp, output logic [3:0] bid);
        bit k;
        resp = 'x; bid = 'x;
        send_aw(a, len, sz, bt, id, k); ok = k;
        for (int i = 0; i <= int'(len); i++) begin send_w(wd[i], ws[i], wl[i], k); ok = ok & k; end
        wait_b(k); ok = ok & k;
        if (k) begin
            resp = axi_bus.b_resp; bid = axi_bus.b_id;
            axi_bus.b_ready = 1'b1; @(posedge clk); #1; axi_bus.b_ready = 1'b0;
        end
    endtask

    task automatic do_read(input logic [63:0] a, input logic [7:0] len, input logic [2:0] sz,
                           input logic [1:0] bt, input logic [3:0] id, output bit ok);
        bit k;
        send_ar(a, len, sz, bt, id, k); ok = k;
        for (int i = 0; i <= int'(len); i++) begin recv_r(rd[i], rr[i], rl[i], ri[i], k); ok = ok & k; end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (axi_bus.aw_ready !== 1'b1) begin failures++; $display("FAIL rst_awready got %b want 1", axi_bus.aw_ready); end
        checks++; if (axi_bus.ar_ready !== 1'b1) begin failures++; $display("FAIL rst_arready got %b want 1", axi_bus.ar_ready); end
        checks++; if (axi_bus.w_ready !== 1'b0) begin failures++; $display("FAIL rst_wready got %b want 0", axi_bus.w_ready); end
        checks++; if (axi_bus.b_valid !== 1'b0) begin failures++; $display("FAIL rst_bvalid got %b want 0", axi_bus.b_valid); end
        checks++; if (axi_bus.r_valid !== 1'b0) begin failures++; $display("FAIL rst_rvalid got %b want 0", axi_bus.r_valid); end
        checks++; if (axi_bus.r_data !== 128'd0) begin failures++; $display("FAIL rst_rdata got %h want 0", axi_bus.r_data); end
        checks++; if (axi_bus.r_last !== 1'b0) begin failures++; $display("FAIL rst_rlast got %b want 0", axi_bus.r_last); end
        rst = 1'b0;
    endtask

    task automatic test_single;
        bit ok; logic [1:0] resp; logic [3:0] bid;
        wd[0] = {16{8'hA5}}; ws[0] = 16'hFFFF; wl[0] = 1'b1;
        do_write(64'h8000_0010, 8'd0, 3'd4, 2'b01, 4'd3, ok, resp, bid);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL single_wr_handshake got %b want 1", ok); end
        checks++; if (bid !== 4'd3) begin failures++; $display("FAIL single_bid got %h want 3", bid); end
        checks++; if (resp !== 2'b00) begin failures++; $display("FAIL single_bresp got %h want 0", resp); end
        send_ar(64'h8000_0010, 8'd0, 3'd4, 2'b01, 4'd5, ok);
        checks++; if (axi_bus.r_valid !== 1'b0) begin failures++; $display("FAIL r_fetch_gap got %b want 0", axi_bus.r_valid); end
        @(posedge clk); #1;
        checks++; if (axi_bus.r_valid !== 1'b1) begin failures++; $display("FAIL r_latency got %b want 1", axi_bus.r_valid); end
        recv_r(rd[0], rr[0], rl[0], ri[0], ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL single_rd_handshake got %b want 1", ok); end
        checks++; if (rd[0] !== {16{8'hA5}}) begin failures++; $display("FAIL single_rdata got %h want a5..a5", rd[0]); end
        checks++; if (ri[0] !== 4'd5) begin failures++; $display("FAIL single_rid got %h want 5", ri[0]); end
        checks++; if (rl[0] !== 1'b1) begin failures++; $display("FAIL single_rlast got %b want 1", rl[0]); end
        checks++; if (rr[0] !== 2'b00) begin failures++; $display("FAIL single_rresp got %h want 0", rr[0]); end
    endtask

    task automatic test_incr;
        bit ok; logic [1:0] resp; logic [3:0] bid; logic [127:0] exp;
        wd[0] = {16{8'h11}}; ws[0] = 16'hFFFF; wl[0] = 1'b1;
        do_write(64'h8000_0020, 8'd0, 3'd4, 2'b01, 4'd1, ok, resp, bid);
        checks++; if (resp !== 2'b00) begin failures++; $display("FAIL incr_prefill_bresp got %h want 0", resp); end
        for (int i = 0; i < 4; i++) begin wd[i] = 128'(i); ws[i] = 16'hFFFF; wl[i] = (i == 3); end
        ws[2] = 16'h00FF;
        do_write(64'h8000_0000, 8'd3, 3'd4, 2'b01, 4'd7, ok, resp, bid);
        checks++; if (ok !== 1'b1 || resp !== 2'b00 || bid !== 4'd7) begin failures++; $display("FAIL incr_wr got ok=%b resp=%h bid=%h want 1/0/7", ok, resp, bid); end
        do_read(64'h8000_0000, 8'd3, 3'd4, 2'b01, 4'd2, ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL incr_rd_handshake got %b want 1", ok); end
        for (int i = 0; i < 4; i++) begin
            exp = (i == 2) ? {64'h1111_1111_1111_1111, 64'd2} : 128'(i);
            checks++; if (rd[i] !== exp) begin failures++; $display("FAIL incr_rdata[%0d] got %h want %h", i, rd[i], exp); end
            checks++; if (rl[i] !== (i == 3)) begin failures++; $display("FAIL incr_rlast[%0d] got %b want %b", i, rl[i], (i == 3)); end
            checks++; if (rr[i] !== 2'b00 || ri[i] !== 4'd2) begin failures++; $display("FAIL incr_rresp_rid[%0d] got %h/%h want 0/2", i, rr[i], ri[i]); end
        end
    endtask

    task automatic test_backpressure;
        bit ok; logic [1:0] resp; logic [3:0] bid;
        wd[0] = 128'hC0; wd[1] = 128'hC1; ws[0] = 16'hFFFF; ws[1] = 16'hFFFF; wl[0] = 1'b0; wl[1] = 1'b1;
        do_write(64'h8000_0080, 8'd1, 3'd4, 2'b01, 4'd0, ok, resp, bid);
        send_ar(64'h8000_0080, 8'd1, 3'd4, 2'b01, 4'd9, ok);
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            if (axi_bus.r_valid) begin ok = 1; break; end
            @(posedge clk); #1;
        end
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL bp_rvalid_wait got %b want 1", ok); end
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            checks++;
            if (axi_bus.r_valid !== 1'b1 || axi_bus.r_data !== 128'hC0 || axi_bus.r_id !== 4'd9 || axi_bus.r_last !== 1'b0) begin
                failures++;
                $display("FAIL bp_r_hold[%0d] got v=%b d=%h id=%h l=%b want 1/c0/9/0", c, axi_bus.r_valid, axi_bus.r_data, axi_bus.r_id, axi_bus.r_last);
            end
        end
        axi_bus.r_ready = 1'b1; @(posedge clk); #1; axi_bus.r_ready = 1'b0;
        recv_r(rd[1], rr[1], rl[1], ri[1], ok);
        checks++; if (ok !== 1'b1 || rd[1] !== 128'hC1 || rl[1] !== 1'b1) begin failures++; $display("FAIL bp_second_beat got ok=%b d=%h l=%b want 1/c1/1", ok, rd[1], rl[1]); end
        send_aw(64'h8000_0090, 8'd0, 3'd4, 2'b01, 4'd6, ok);
        send_w(128'hB0, 16'hFFFF, 1'b1, ok);
        wait_b(ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL bp_bvalid_wait got %b want 1", ok); end
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            checks++; if (axi_bus.b_valid !== 1'b1 || axi_bus.b_id !== 4'd6) begin failures++; $display("FAIL bp_b_hold[%0d] got v=%b id=%h want 1/6", c, axi_bus.b_valid, axi_bus.b_id); end
        end
        axi_bus.b_ready = 1'b1; @(posedge clk); #1; axi_bus.b_ready = 1'b0;
        checks++; if (axi_bus.b_valid !== 1'b0 || axi_bus.aw_ready !== 1'b1) begin failures++; $display("FAIL bp_b_release got v=%b awr=%b want 0/1", axi_bus.b_valid, axi_bus.aw_ready); end
    endtask

    task automatic test_errors;
        bit ok; logic [1:0] resp; logic [3:0] bid;
        do_read(64'h8001_0000, 8'd0, 3'd4, 2'b01, 4'd1, ok);
        checks++; if (ok !== 1'b1 || rd[0] !== 128'd0 || rr[0] !== 2'b11 || rl[0] !== 1'b1) begin failures++; $display("FAIL rd_decerr got ok=%b d=%h r=%h l=%b want 1/0/3/1", ok, rd[0], rr[0], rl[0]); end
        do_read(64'h8000_FFF0, 8'd0, 3'd4, 2'b01, 4'd1, ok);
        checks++; if (rr[0] !== 2'b00) begin failures++; $display("FAIL rd_top_word got %h want 0", rr[0]); end
        wd[0] = 128'hBAD; ws[0] = 16'hFFFF; wl[0] = 1'b1;
        do_write(64'h7FFF_FFF0, 8'd0, 3'd4, 2'b01, 4'd2, ok, resp, bid);
        checks++; if (resp !== 2'b11) begin failures++; $display("FAIL wr_decerr got %h want 3", resp); end
        wd[0] = 128'hE0; wd[1] = 128'hE1; ws[1] = 16'hFFFF; wl[0] = 1'b1; wl[1] = 1'b1;
        do_write(64'h8000_0040, 8'd1, 3'd4, 2'b01, 4'd2, ok, resp, bid);
        checks++; if (ok !== 1'b1 || resp !== 2'b10) begin failures++; $display("FAIL wr_early_wlast got ok=%b resp=%h want 1/2", ok, resp); end
        wd[0] = {8{16'hDEAD}}; wd[1] = {8{16'hBEEF}}; wl[0] = 1'b0;
        do_write(64'h8000_0040, 8'd1, 3'd4, 2'b10, 4'd2, ok, resp, bid);
        checks++; if (ok !== 1'b1 || resp !== 2'b10) begin failures++; $display("FAIL wr_wrap got ok=%b resp=%h want 1/2", ok, resp); end
        do_read(64'h8000_0040, 8'd1, 3'd4, 2'b01, 4'd3, ok);
        checks++; if (rd[0] !== 128'hE0 || rd[1] !== 128'hE1) begin failures++; $display("FAIL wrap_mem_kept got %h %h want e0 e1", rd[0], rd[1]); end
        do_read(64'h8000_0040, 8'd1, 3'd4, 2'b10, 4'd3, ok);
        checks++; if (ok !== 1'b1 || rr[0] !== 2'b10 || rr[1] !== 2'b10 || rd[0] !== 128'd0 || rl[1] !== 1'b1) begin failures++; $display("FAIL rd_wrap got r=%h/%h d=%h l=%b want 2/2/0/1", rr[0], rr[1], rd[0], rl[1]); end
        do_read(64'h8000_0040, 8'd0, 3'd5, 2'b01, 4'd3, ok);
        checks++; if (rr[0] !== 2'b10) begin failures++; $display("FAIL rd_bigsize got %h want 2", rr[0]); end
    endtask

    task automatic test_reset_mid;
        bit ok; logic [1:0] resp; logic [3:0] bid; logic [127:0] exp;
        for (int i = 0; i < 8; i++) begin wd[i] = 128'(32'h100 + i); ws[i] = 16'hFFFF; wl[i] = (i == 7); end
        do_write(64'h8000_0100, 8'd7, 3'd4, 2'b01, 4'd4, ok, resp, bid);
        checks++; if (ok !== 1'b1 || resp !== 2'b00) begin failures++; $display("FAIL mid_prefill got ok=%b resp=%h want 1/0", ok, resp); end
        send_aw(64'h8000_0100, 8'd7, 3'd4, 2'b01, 4'd4, ok);
        send_w(128'h200, 16'hFFFF, 1'b0, ok);
        send_w(128'h201, 16'hFFFF, 1'b0, ok);
        axi_bus.w_data = 128'h202; axi_bus.w_strb = 16'hFFFF; axi_bus.w_last = 1'b0; axi_bus.w_valid = 1'b1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; axi_bus.w_valid = 1'b0;
        checks++; if (axi_bus.aw_ready !== 1'b1 || axi_bus.w_ready !== 1'b0) begin failures++; $display("FAIL mid_idle got awr=%b wr=%b want 1/0", axi_bus.aw_ready, axi_bus.w_ready); end
        repeat (3) begin @(posedge clk); #1; end
        checks++; if (axi_bus.b_valid !== 1'b0) begin failures++; $display("FAIL mid_no_b got %b want 0", axi_bus.b_valid); end
        do_read(64'h8000_0100, 8'd3, 3'd4, 2'b01, 4'd8, ok);
        for (int i = 0; i < 4; i++) begin
            exp = (i < 2) ? 128'(32'h200 + i) : 128'(32'h100 + i);
            checks++; if (rd[i] !== exp) begin failures++; $display("FAIL mid_rdata[%0d] got %h want %h", i, rd[i], exp); end
        end
    endtask

    initial begin
        axi_bus.aw_valid = 1'b0; axi_bus.aw_id = '0; axi_bus.aw_addr = '0; axi_bus.aw_len = '0;
        axi_bus.aw_size = '0; axi_bus.aw_burst = '0;
        axi_bus.w_valid = 1'b0; axi_bus.w_data = '0; axi_bus.w_strb = '0; axi_bus.w_last = 1'b0;
        axi_bus.b_ready = 1'b0;
        axi_bus.ar_valid = 1'b0; axi_bus.ar_id = '0; axi_bus.ar_addr = '0; axi_bus.ar_len = '0;
        axi_bus.ar_size = '0; axi_bus.ar_burst = '0;
        axi_bus.r_ready = 1'b0;
        test_reset;
        test_single;
        test_incr;
        test_backpressure;
        test_errors;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
